// File: rtl/axis_reg_slice_pipe.sv
// ---------------------------------------------------------------------------
// axis_reg_slice_pipe
//
// A chain of STAGES full valid/ready register slices, used to pipeline long
// routes between stream blocks. Each stage holds a main register (which
// drives the stage output) and a skid register (which catches the beat that
// arrives in the cycle the stage stalls). Valid, data, last and ready are
// all registered at every stage boundary. The chain therefore gives timing
// isolation in both directions while still sustaining one beat per cycle.
// Capacity is 2*STAGES beats.
//
// Ports:
//   aclk_i     clock, all logic on the rising edge
//   aresetn_i  synchronous reset, active-low, highest priority
//   flush_i    synchronous flush; discards every held beat and any beat
//              offered in the same cycle
//   valid_i / ready_o / data_i / last_i   upstream stream
//                                         (ready_o comes from a flop)
//   valid_o / ready_i / data_o / last_o   downstream stream
//                                         (valid_o, data_o and last_o
//                                         come from flops)
//   count_o    number of beats currently held, 0..2*STAGES
// ---------------------------------------------------------------------------
module axis_reg_slice_pipe #(
  parameter  int DWIDTH = 8,
  parameter  int STAGES = 2,
  localparam int CWIDTH = $clog2(2 * STAGES + 1)
) (
  input  logic              aclk_i,
  input  logic              aresetn_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              last_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              last_o,
  output logic [CWIDTH-1:0] count_o
);

  // {last, data} travel together as one word through every stage.
  localparam int WW = DWIDTH + 1;

  // Per-stage views, collected so that neighbouring stages can see them.
  logic [STAGES-1:0] m_valid_s;
  logic [STAGES-1:0] in_ready_s;
  logic [WW-1:0]     m_word_s [STAGES];

  logic              in_fire_s;
  logic              out_fire_s;
  logic [CWIDTH-1:0] count_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          st_in_valid_s;
    logic [WW-1:0] st_in_word_s;
    logic          st_out_ready_s;
    logic          skid_valid_s;
    logic          load_s;

    logic          m_valid_r;
    logic [WW-1:0] m_word_r;
    logic [WW-1:0] s_word_r;
    // The stage's ready is kept as its own flop, and the skid-valid flag is
    // its complement. This lets the ready towards the upstream neighbour
    // come straight from a register.
    logic          in_ready_r;

    if (k == 0) begin : g_head
      assign st_in_valid_s = valid_i;
      assign st_in_word_s  = {last_i, data_i};
    end else begin : g_link
      assign st_in_valid_s = m_valid_s[k-1];
      assign st_in_word_s  = m_word_s[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign st_out_ready_s = ready_i;
    end else begin : g_mid
      assign st_out_ready_s = in_ready_s[k+1];
    end

    assign skid_valid_s = ~in_ready_r;
    // The main register may take a new word when its current word leaves,
    // or when it is empty.
    assign load_s       = st_out_ready_s | ~m_valid_r;

    // Stage register update: refill main from skid first, otherwise take
    // the input directly, otherwise park a stalled input beat in the skid.
    always_ff @(posedge aclk_i) begin
      if (!aresetn_i) begin
        m_valid_r  <= 1'b0;
        in_ready_r <= 1'b1;
        m_word_r   <= {WW{1'b0}};
        s_word_r   <= {WW{1'b0}};
      end else if (flush_i) begin
        // Data registers hold; only the valid flags are cleared.
        m_valid_r  <= 1'b0;
        in_ready_r <= 1'b1;
      end else if (load_s && skid_valid_s) begin
        m_valid_r  <= 1'b1;
        m_word_r   <= s_word_r;
        in_ready_r <= 1'b1;
      end else if (load_s) begin
        m_valid_r <= st_in_valid_s;
        if (st_in_valid_s) begin
          m_word_r <= st_in_word_s;
        end else begin
          m_word_r <= m_word_r;
        end
      end else if (st_in_valid_s && skid_valid_s == 1'b0) begin
        // Downstream stalled while a beat was accepted: park it.
        s_word_r   <= st_in_word_s;
        in_ready_r <= 1'b0;
      end else begin
        m_valid_r  <= m_valid_r;
        in_ready_r <= in_ready_r;
      end
    end

    assign m_valid_s[k]  = m_valid_r;
    assign m_word_s[k]   = m_word_r;
    assign in_ready_s[k] = in_ready_r;
  end

  assign ready_o = in_ready_s[0];
  assign valid_o = m_valid_s[STAGES-1];
  assign data_o  = m_word_s[STAGES-1][DWIDTH-1:0];
  assign last_o  = m_word_s[STAGES-1][DWIDTH];

  assign in_fire_s  = valid_i & in_ready_s[0];
  assign out_fire_s = m_valid_s[STAGES-1] & ready_i;

  // Occupancy counter. An input and an output transfer in the same cycle
  // cancel. A flush clears the counter, so any transfer in that cycle is
  // ignored.
  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      count_r <= {CWIDTH{1'b0}};
    end else if (flush_i) begin
      count_r <= {CWIDTH{1'b0}};
    end else begin
      case ({in_fire_s, out_fire_s})
        2'b10:   count_r <= count_r + {{(CWIDTH-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CWIDTH-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign count_o = count_r;

endmodule

// File: tb/tb_axis_reg_slice_pipe.sv
module tb_axis_reg_slice_pipe;

  localparam int DW = 8;
  localparam int ST = 2;
  localparam int CW = $clog2(2 * ST + 1);

  logic          aclk_i = 1'b0;
  logic          aresetn_i;
  logic          flush_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          last_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic [CW-1:0] count_o;

  always #5 aclk_i = ~aclk_i;

  axis_reg_slice_pipe #(.DWIDTH(DW), .STAGES(ST)) dut (
    .aclk_i   (aclk_i),
    .aresetn_i(aresetn_i),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .last_i   (last_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .last_o   (last_o),
    .count_o  (count_o)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  // Reference model: the beats held, oldest first.
  logic [DW:0] q [$];

  bit          chk_en = 1'b0;
  bit          in_fire_q, out_fire_q;
  bit          hold_r = 1'b0;
  logic [DW:0] hold_word;
  int          out_cnt = 0;

  // Samples of the DUT outputs taken in the most recent step.
  logic          smp_valid, smp_ready, smp_last;
  logic [DW-1:0] smp_data;
  logic [CW-1:0] smp_count;

  // Latency tracker for one chosen word.
  bit          trk_on = 1'b0;
  logic [DW:0] trk_word;
  int          t_in, t_out;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample and check at the negedge, update the model at
  // the posedge, then leave 1 time unit for the caller to drive inputs.
  task automatic step();
    logic [DW:0] w;
    bit rst_n, fl;
    @(negedge aclk_i);
    rst_n      = aresetn_i;
    fl         = flush_i;
    w          = {last_i, data_i};
    in_fire_q  = valid_i && ready_o && rst_n && !fl;
    out_fire_q = valid_o && ready_i;
    smp_valid  = valid_o;
    smp_ready  = ready_o;
    smp_data   = data_o;
    smp_last   = last_o;
    smp_count  = count_o;
    if (chk_en) begin
      check_eq("count", count_o, q.size());
      if (valid_o) begin
        if (q.size() == 0) check_eq("vld_when_empty", valid_o, 0);
        else               check_eq("head", {last_o, data_o}, q[0]);
      end
      if (hold_r) begin
        check_eq("hold_vld", valid_o, 1);
        check_eq("hold_word", {last_o, data_o}, hold_word);
      end
      if (q.size() == 2 * ST) check_eq("full_rdy", ready_o, 0);
    end
    hold_r    = valid_o && !ready_i && rst_n && !fl;
    hold_word = {last_o, data_o};
    if (trk_on) begin
      if (in_fire_q && w == trk_word && t_in < 0) t_in = cyc;
      if (valid_o && {last_o, data_o} == trk_word && t_in >= 0 && t_out < 0) t_out = cyc;
    end
    @(posedge aclk_i);
    cyc++;
    if (out_fire_q) out_cnt++;
    if (!rst_n || fl) begin
      q.delete();
    end else begin
      if (out_fire_q && q.size() > 0) void'(q.pop_front());
      if (in_fire_q) q.push_back(w);
    end
    #1;
  endtask

  task automatic drain();
    valid_i = 1'b0;
    ready_i = 1'b1;
    flush_i = 1'b0;
    repeat (2 * ST + 4) step();
    check_eq("drain_count", smp_count, 0);
  endtask

  task automatic arm(input logic [DW:0] w);
    trk_on   = 1'b1;
    trk_word = w;
    t_in     = -1;
    t_out    = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int guard;
    int i;
    int oc;
    logic [DW-1:0] d;

    // ---------------- reset ----------------
    aresetn_i = 1'b0;
    flush_i   = 1'b0;
    valid_i   = 1'b1;
    data_i    = 8'h3C;
    last_i    = 1'b0;
    ready_i   = 1'b0;
    step();
    chk_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      if (r == 2) aresetn_i = 1'b1;
      step();
      check_eq("rst_valid", smp_valid, 0);
      check_eq("rst_ready", smp_ready, 1);
      check_eq("rst_count", smp_count, 0);
      check_eq("rst_data", smp_data, 0);
      check_eq("rst_last", smp_last, 0);
    end
    drain();

    // ---------------- streaming ----------------
    ready_i = 1'b1;
    out_cnt = 0;
    arm(9'h000);
    i = 0;
    guard = 0;
    while (i < 16 && guard < 100) begin
      valid_i = 1'b1;
      data_i  = DW'(i);
      last_i  = (i == 15);
      oc = out_cnt;
      step();
      if (t_out >= 0 && oc < 16) check_eq("stream_vld", smp_valid, 1);
      if (in_fire_q) i++;
      guard++;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    guard = 0;
    while (out_cnt < 16 && guard < 20) begin
      oc = out_cnt;
      step();
      if (t_out >= 0 && oc < 16) check_eq("stream_vld", smp_valid, 1);
      guard++;
    end
    check_eq("stream_beats", out_cnt, 16);
    check_eq("stream_latency", t_out - t_in, ST);
    trk_on = 1'b0;
    drain();

    // ---------------- full backpressure ----------------
    ready_i = 1'b0;
    valid_i = 1'b1;
    d   = 8'h10;
    acc = 0;
    repeat (8) begin
      data_i = d;
      step();
      if (in_fire_q) begin
        d++;
        acc++;
      end
    end
    check_eq("bp_accepted", acc, 2 * ST);
    check_eq("bp_ready", smp_ready, 0);
    check_eq("bp_count", smp_count, 2 * ST);
    check_eq("bp_data", smp_data, 8'h10);
    ready_i = 1'b1;
    guard = 0;
    while (d != 8'h18 && guard < 40) begin
      data_i = d;
      step();
      if (in_fire_q) d++;
      guard++;
    end
    check_eq("bp_resume", d, 8'h18);
    drain();

    // ---------------- flush ----------------
    ready_i = 1'b0;
    valid_i = 1'b1;
    acc = 0;
    guard = 0;
    while (acc < 3 && guard < 10) begin
      data_i = 8'h20 + DW'(acc);
      step();
      if (in_fire_q) acc++;
      guard++;
    end
    flush_i = 1'b1;
    data_i  = 8'hAA;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    step();
    check_eq("flush_valid", smp_valid, 0);
    check_eq("flush_count", smp_count, 0);
    check_eq("flush_ready", smp_ready, 1);
    ready_i = 1'b1;
    repeat (2 * ST + 2) begin
      step();
      check_eq("flush_no_out", smp_valid, 0);
    end

    // ---------------- reset mid-stream ----------------
    ready_i = 1'b0;
    valid_i = 1'b1;
    acc = 0;
    guard = 0;
    while (acc < 4 && guard < 12) begin
      data_i = 8'h40 + DW'(acc);
      step();
      if (in_fire_q) acc++;
      guard++;
    end
    check_eq("mid_fill", smp_count + in_fire_q, 4);
    aresetn_i = 1'b0;
    valid_i   = 1'b0;
    step();
    aresetn_i = 1'b1;
    step();
    check_eq("mid_count", smp_count, 0);
    check_eq("mid_valid", smp_valid, 0);
    arm(9'h055);
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h55;
    guard = 0;
    while (t_in < 0 && guard < 10) begin
      step();
      guard++;
    end
    valid_i = 1'b0;
    repeat (ST + 2) step();
    check_eq("mid_latency", t_out - t_in, ST);
    trk_on = 1'b0;
    drain();

    // ---------------- random stress ----------------
    repeat (3000) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
      data_i  = DW'($urandom);
      last_i  = 1'($urandom_range(0, 1));
      flush_i = ($urandom_range(0, 99) == 0);
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_reg_slice_pipe.md
Name: axis_reg_slice_pipe

Overview:
- Parametrised successor to the single-stage valid/ready register slice: a chain of STAGES full register slices (main + skid register per stage) between an upstream and a downstream valid/ready stream.
- Valid, data, last and ready are all registered at every stage boundary, giving timing isolation on both directions with full throughput (1 beat/cycle).
- Data passes through unmodified. Adds a TLAST sideband, a synchronous flush and an occupancy counter.
- Used to pipeline long routes between stream blocks.

Parameters:
- DWIDTH, 8, data width in bits (>=1).
- STAGES, 2, number of cascaded register-slice stages (1..8). Capacity 2*STAGES beats.
- CWIDTH (localparam), $clog2(2*STAGES+1), width of count_o.

Ports:
- aclk_i  in  1  clock; all logic on rising edge.
- aresetn_i  in  1  synchronous reset, active-low.
- flush_i  in  1  synchronous flush; discards all held beats.
- valid_i  in  1  upstream beat valid.
- ready_o  out  1  upstream ready; driven directly from a flop.
- data_i  in  DWIDTH  upstream data.
- last_i  in  1  upstream end-of-packet marker.
- valid_o  out  1  downstream beat valid; driven from a flop.
- ready_i  in  1  downstream ready.
- data_o  out  DWIDTH  downstream data.
- last_o  out  1  downstream end-of-packet marker.
- count_o  out  CWIDTH  number of beats currently held, 0..2*STAGES.

Behaviour:
- Transfer rules:
  - Input transfer: valid_i & ready_o.
  - Output transfer: valid_o & ready_i.
  - {data, last} are moved as one word.
- Per-stage state:
  - main register m_valid/m_data/m_last, which drives the stage output.
  - skid register s_valid/s_data/s_last.
- Stage ports:
  - stage in_ready = ~s_valid (registered).
  - stage out_valid = m_valid.
  - stage out_data = m_data.
  - Stage k output feeds stage k+1 input. Stage 0 input is the upstream port; stage STAGES-1 output is the downstream port.
- Per-stage update each clock (load = out_ready | ~m_valid):
  - load & s_valid: m <= s, s_valid <= 0. No input is accepted, since in_ready=0.
  - load & ~s_valid: m_valid <= in_valid; m_data/m_last <= input when in_valid.
  - ~load & in_valid & ~s_valid: s <= input, s_valid <= 1. A stalled input beat is captured, never lost.
  - ~load otherwise: hold.
- Data registers update only when their valid is loaded; data values are don't-care while valid=0.
- Latency: a beat presented with ready_i held high appears on valid_o exactly STAGES cycles after its input transfer cycle.
- Throughput: sustained 1 beat/cycle with ready_i=1. No bubbles are inserted.
- Backpressure:
  - With ready_i=0 the chain absorbs exactly 2*STAGES beats; ready_o then reads 0.
  - ready_o returns to 1 no earlier than 1 cycle after downstream draining begins, due to the per-stage registered ready.
- Ordering: output order equals input order, with no duplication or loss, under any valid_i/ready_i pattern.
- Stream rules:
  - valid_o never drops, and data_o/last_o never change, while valid_o=1 & ready_i=0.
  - valid_o is not dependent combinationally on ready_i.
- count_o:
  - Registered; count <= count + in_fire - out_fire.
  - Simultaneous input and output transfers leave it unchanged.
  - Never exceeds 2*STAGES and never underflows.
- Reset (aresetn_i=0, highest priority): all m_valid, s_valid and count_o cleared to 0.
  - ready_o=1 and valid_o=0 from the first cycle after the reset edge.
  - data_o and last_o reset to 0.
- flush_i=1 (aresetn_i=1): same clearing as reset for valids and count; data registers hold.
  - Any beat presented on valid_i in the flush cycle is dropped, even if ready_o=1.
  - Any output transfer in that cycle still completes downstream but is not counted.
- Reset or flush mid-packet: partial packet discarded; no last-repair is performed.

Test Plan:
- Reset: hold aresetn_i=0 for 3 cycles with valid_i=1 -> valid_o=0, ready_o=1, count_o=0, data_o=0, last_o=0 during and 1 cycle after release.
- Streaming (STAGES=2, ready_i=1): send 0x00..0x0F back-to-back, last on 0x0F -> valid_o high continuously, 0x00 out 2 cycles after input, order exact, last_o only with 0x0F, count_o steady at 2.
- Full backpressure (STAGES=2): ready_i=0, valid_i=1 with 0x10,0x11,... -> exactly 4 accepted (0x10..0x13), ready_o=0, count_o=4, data_o stable at 0x10. Then ready_i=1 -> 0x10..0x13 then subsequent beats, no loss or duplicate.
- Random stress (STAGES=1,3,8, DWIDTH=8/32): random valid_i and ready_i at 50% for 10k beats -> scoreboard exact order match, stability rule holds, count_o equals scoreboard occupancy every cycle.
- Flush: fill 3 beats with ready_i=0, assert flush_i for 1 cycle with valid_i=1 data 0xAA -> next cycle valid_o=0, count_o=0, ready_o=1; 0xAA never appears at output.
- Reset mid-stream: with 4 beats held, pull aresetn_i low for 1 cycle -> all beats discarded, count_o=0; next beat 0x55 emerges after STAGES cycles.
